audio_tx_arbiter: RTL and testbench

- Shares the single write port of the audio TX FIFO between two stereo sample sources, e.g. the VLC modulator and a test-tone generator.
- The serial output stage drains that FIFO, reading left and then right at each frame start.
- The arbiter accepts whole stereo frames ({left,right}) from the requesters.
- It writes each frame as two consecutive FIFO words, left then right, so channel alignment is never broken.

---
 rtl/audio_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_audio_tx_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/audio_tx_arbiter.sv
// audio_tx_arbiter: shares the audio TX FIFO write port between two stereo
// frame sources. A granted frame is buffered and written as two consecutive
// FIFO words (left, then right) so L/R alignment is never broken.
//
// Handshake: a frame transfers on the rising mclk edge where reqN_valid and
// reqN_ready are both 1. ready is only offered in IDLE with enable=1, to at
// most one requester, and never depends on anything but valid, enable, state
// and last_grant, so a requester may hold valid while waiting.
module audio_tx_arbiter #(
  parameter int DW            = 16,
  parameter int PRIORITY_MODE = 0
) (
  input  logic            mclk,
  input  logic            reset,
  input  logic            enable,
  input  logic            req0_valid,
  input  logic [2*DW-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [2*DW-1:0] req1_data,
  output logic            req1_ready,
  output logic            winc,
  output logic [DW-1:0]   wdata,
  input  logic            wfull,
  output logic            busy,
  output logic            grant,
  output logic [15:0]     frames_written,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR_L = 2'd1,
    S_WR_R = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2*DW-1:0]   buf_q, buf_d;
  logic [15:0]       frames_q, frames_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;

  // Combinational arbitration results shared by next-state and outputs.
  logic              sel;
  logic              accept;

  // State register: all flops, synchronous active-high reset.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      frames_q     <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      frames_q     <= frames_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: accept a frame in IDLE, then walk left/right writes,
  // holding in place whenever the FIFO reports full.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    frames_d     = frames_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          buf_d   = sel ? req1_data : req0_data;
          grant_d = sel;
          state_d = S_WR_L;
        end
      end
      S_WR_L: begin
        if (!wfull) state_d = S_WR_R;
      end
      S_WR_R: begin
        if (!wfull) begin
          frames_d     = frames_q + 16'd1;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: requester selection, ready strobes and FIFO write port.
  always_comb begin
    if (PRIORITY_MODE == 1) begin
      sel = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      sel = ~last_grant_q;
    end else begin
      sel = req1_valid;
    end
    accept     = (state_q == S_IDLE) && enable && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept && sel;
    winc       = 1'b0;
    wdata      = '0;
    unique case (state_q)
      S_WR_L: begin
        winc  = ~wfull;
        wdata = winc ? buf_q[2*DW-1:DW] : '0;
      end
      S_WR_R: begin
        winc  = ~wfull;
        wdata = winc ? buf_q[DW-1:0] : '0;
      end
      default: ;
    endcase
    busy           = (state_q != S_IDLE);
    grant          = grant_q;
    frames_written = frames_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_audio_tx_arbiter.sv
// Bench for audio_tx_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus; each is checked every cycle against a frame-level
// model built on a queue of pending FIFO words.
module tb_audio_tx_arbiter;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2*DW-1:0] req0_data = '0, req1_data = '0;
  logic            wfull = 1'b0;

  logic            r0[2], r1[2], winc[2], busy[2], grant[2];
  logic [DW-1:0]   wdata[2];
  logic [15:0]     fw[2];
  logic [1:0]      dbg[2];

  audio_tx_arbiter #(.DW(DW), .PRIORITY_MODE(0)) u_rr (
    .mclk(mclk), .reset(reset), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1[0]),
    .winc(winc[0]), .wdata(wdata[0]), .wfull(wfull), .busy(busy[0]),
    .grant(grant[0]), .frames_written(fw[0]), .dbg_state(dbg[0])
  );

  audio_tx_arbiter #(.DW(DW), .PRIORITY_MODE(1)) u_fp (
    .mclk(mclk), .reset(reset), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1[1]),
    .winc(winc[1]), .wdata(wdata[1]), .wfull(wfull), .busy(busy[1]),
    .grant(grant[1]), .frames_written(fw[1]), .dbg_state(dbg[1])
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Expected FIFO words still owed by each instance (index 0 = RR, 1 = FP).
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          m_last[2];
  logic          m_grant[2];
  logic [15:0]   m_frames[2];

  function automatic int pend_size(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [DW-1:0] pend_front(input int m);
    return (m == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic pend_pop(input int m);
    if (m == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic pend_push(input int m, input logic [DW-1:0] w);
    if (m == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int m = 0; m < 2; m++) begin
      m_last[m]   = 1'b1;
      m_grant[m]  = 1'b0;
      m_frames[m] = 16'd0;
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, check both instances, then advance the model
  // to reflect the coming rising edge.
  task automatic cycle(input logic rst, input logic en, input logic v0, input logic [2*DW-1:0] d0,
                       input logic v1, input logic [2*DW-1:0] d1, input logic wf);
    logic          m_busy, any, sel, acc, e_winc;
    logic [DW-1:0] e_wdata;
    string         p;
    @(negedge mclk);
    reset = rst; enable = en; wfull = wf;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    for (int m = 0; m < 2; m++) begin
      p      = (m == 0) ? "rr" : "fp";
      m_busy = (pend_size(m) != 0);
      any    = v0 | v1;
      if (m == 1)        sel = !v0;
      else if (v0 && v1) sel = !m_last[m];
      else               sel = v1;
      acc     = !m_busy && en && any;
      e_winc  = m_busy && !wf;
      e_wdata = e_winc ? pend_front(m) : '0;
      check({p, "_req0_ready"}, 32'(r0[m]), 32'(acc && !sel));
      check({p, "_req1_ready"}, 32'(r1[m]), 32'(acc && sel));
      check({p, "_winc"},       32'(winc[m]), 32'(e_winc));
      check({p, "_wdata"},      32'(wdata[m]), 32'(e_wdata));
      check({p, "_busy"},       32'(busy[m]), 32'(m_busy));
      check({p, "_frames"},     32'(fw[m]), 32'(m_frames[m]));
      if (m_busy) check({p, "_grant"}, 32'(grant[m]), 32'(m_grant[m]));
      if (!rst) begin
        if (e_winc) begin
          pend_pop(m);
          if (pend_size(m) == 0) begin
            m_frames[m] = m_frames[m] + 16'd1;
            m_last[m]   = m_grant[m];
          end
        end
        if (acc) begin
          pend_push(m, sel ? d1[2*DW-1:DW] : d0[2*DW-1:DW]);
          pend_push(m, sel ? d1[DW-1:0] : d0[DW-1:0]);
          m_grant[m] = sel;
        end
      end
    end
    if (rst) model_reset();
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // Reset: hold for a few cycles; every output must sit at its reset value.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check("reset_grant_rr", 32'(grant[0]), 32'd0);
    check("reset_grant_fp", 32'(grant[1]), 32'd0);

    // Single requester, no backpressure: a frame every 3 cycles.
    repeat (12) cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, '0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

    // Both requesters continuously valid: RR alternates, FP stays on req0.
    repeat (18) cycle(1'b0, 1'b1, 1'b1, 32'h0A0A_0B0B, 1'b1, 32'h1C1C_1D1D, 1'b0);
    // Drop req0: FP moves to req1 on its next IDLE cycle.
    repeat (9) cycle(1'b0, 1'b1, 1'b0, 32'h0A0A_0B0B, 1'b1, 32'h1C1C_1D1D, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    // Backpressure: accept, write left, then full for 5 cycles in WR_R.
    cycle(1'b0, 1'b1, 1'b1, 32'hAAAA_5555, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

    // Enable drops during WR_L: frame still completes, no new grant.
    cycle(1'b0, 1'b1, 1'b1, 32'hBEEF_CAFE, 1'b1, 32'hFACE_F00D, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 1'b0);

    // Reset during WR_R, then next grant goes to req0.
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h7777_8888, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (7) cycle(1'b0, 1'b1, 1'b1, 32'h0102_0304, 1'b1, 32'h0506_0708, 1'b0);

    // Randomized traffic: data changes every cycle to show it is only
    // sampled on the handshake edge.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
